// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted through a
// valid/ready handshake and shifted out one bit per accepted serial beat. The
// first and last bits of each word are flagged. When a new word is offered on
// the last-bit beat, it is loaded on that same edge, so consecutive words
// stream with no idle cycle between them.
//
// Parameters
//   WIDTH      parallel word width in bits (>= 2)
//   LSB_FIRST  0: bit WIDTH-1 leaves first, 1: bit 0 leaves first
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   par_data   parallel word to transmit
//   par_valid  par_data is valid
//   par_ready  block can take a word this cycle
//   ser_out    current serial bit (driven 0 when ser_valid is low)
//   ser_valid  ser_out holds a valid bit
//   ser_ready  downstream accepts ser_out this cycle
//   ser_first  ser_out is the first bit of a word
//   ser_last   ser_out is the last bit of a word
//   busy       a word is in flight
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  logic w_in_shift;
  logic w_at_last;
  logic w_beat;
  logic w_load;
  logic w_out_bit;

  // Move the word one position toward the output end, zero-filling behind it.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    if (LSB_FIRST) begin
      res = {1'b0, v[WIDTH-1:1]};
    end else begin
      res = {v[WIDTH-2:0], 1'b0};
    end
    return res;
  endfunction

  // Handshake decode. par_ready in SHIFT opens only on the last-bit beat so a
  // new word can be loaded on the same edge that retires the old one.
  always_comb begin
    w_in_shift = (r_state == S_SHIFT);
    w_at_last  = (r_cnt == LAST_IDX);
    w_beat     = w_in_shift && ser_ready;
    par_ready  = 1'b0;
    case (r_state)
      S_IDLE:  par_ready = ~reset;
      S_SHIFT: par_ready = ~reset & w_at_last & ser_ready;
      default: par_ready = 1'b0;
    endcase
    w_load = par_valid && par_ready;
  end

  // Next-state, shift-register and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = par_data;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_beat) begin
          if (w_at_last) begin
            if (w_load) begin
              w_state_nxt = S_SHIFT;
              w_shift_nxt = par_data;
              w_cnt_nxt   = CNT_ZERO;
            end else begin
              // Word finished; counter returns to 0 rather than wrapping.
              w_state_nxt = S_IDLE;
              w_shift_nxt = {WIDTH{1'b0}};
              w_cnt_nxt   = CNT_ZERO;
            end
          end else begin
            w_shift_nxt = shift_once(r_shift);
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end else begin
          // Stalled: everything holds.
          w_state_nxt = S_SHIFT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_shift_nxt = {WIDTH{1'b0}};
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= {WIDTH{1'b0}};
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Serial outputs are decoded from registers only; par_data never reaches
  // ser_out combinationally.
  always_comb begin
    w_out_bit = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
    ser_valid = w_in_shift;
    busy      = w_in_shift;
    ser_out   = w_in_shift & w_out_bit;
    ser_first = w_in_shift & (r_cnt == CNT_ZERO);
    ser_last  = w_in_shift & w_at_last;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Self-checking bench for piso_serializer. Two instances: a 32-bit MSB-first
// one and an 8-bit LSB-first one. Every accepted word pushes its expected bit
// stream (bit, first, last) onto a queue; every serial beat pops and compares.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic [31:0] p32_data;
  logic        p32_valid, p32_ready;
  logic        s32_out, s32_valid, s32_ready, s32_first, s32_last, busy32;

  logic [7:0]  p8_data;
  logic        p8_valid, p8_ready;
  logic        s8_out, s8_valid, s8_ready, s8_first, s8_last, busy8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] q32[$];
  logic [2:0] q8[$];

  piso_serializer #(.WIDTH(32), .LSB_FIRST(1'b0)) dut32 (
    .clk(clk), .reset(reset),
    .par_data(p32_data), .par_valid(p32_valid), .par_ready(p32_ready),
    .ser_out(s32_out), .ser_valid(s32_valid), .ser_ready(s32_ready),
    .ser_first(s32_first), .ser_last(s32_last), .busy(busy32)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .clk(clk), .reset(reset),
    .par_data(p8_data), .par_valid(p8_valid), .par_ready(p8_ready),
    .ser_out(s8_out), .ser_valid(s8_valid), .ser_ready(s8_ready),
    .ser_first(s8_first), .ser_last(s8_last), .busy(busy8)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: retire one expected bit per serial beat, then enqueue any word accepted this cycle.
  always @(negedge clk) begin
    logic [2:0] e;
    if (reset) begin
      q32.delete();
      q8.delete();
    end else begin
      if (s32_valid && s32_ready) begin
        if (q32.size() == 0) begin
          check_value("sb32_unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = q32.pop_front();
          check_value("sb32_bit_first_last", {29'd0, s32_out, s32_first, s32_last}, {29'd0, e});
          check_value("sb32_busy", {31'd0, busy32}, 32'd1);
        end
      end
      if (s8_valid && s8_ready) begin
        if (q8.size() == 0) begin
          check_value("sb8_unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          check_value("sb8_bit_first_last", {29'd0, s8_out, s8_first, s8_last}, {29'd0, e});
        end
      end
      if (p32_valid && p32_ready) begin
        for (int k = 0; k < 32; k++) q32.push_back({p32_data[31-k], (k == 0), (k == 31)});
      end
      if (p8_valid && p8_ready) begin
        for (int k = 0; k < 8; k++) q8.push_back({p8_data[k], (k == 0), (k == 7)});
      end
    end
  end

  // Offer a word to dut32 until accepted; returns number of cycles waited.
  task automatic send32(input logic [31:0] d, input bit keep, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    p32_data  = d;
    p32_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      waits++;
      @(negedge clk);
      if (p32_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    if (!keep) p32_valid = 1'b0;
    if (!acc) check_value("send32_timeout", 32'd0, 32'd1);
  endtask

  task automatic send8(input logic [7:0] d, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    p8_data  = d;
    p8_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      waits++;
      @(negedge clk);
      if (p8_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    p8_valid = 1'b0;
    if (!acc) check_value("send8_timeout", 32'd0, 32'd1);
  endtask

  // Count contiguous ser_valid cycles of dut32, then check the idle cycle after.
  task automatic drain32(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!s32_valid) break;
      n++;
      @(posedge clk); #1;
    end
    check_value({tag, "_busy_after"}, {31'd0, busy32}, 32'd0);
    check_value({tag, "_ready_after"}, {31'd0, p32_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Two words on dut32; the second is offered 'gap' cycles into the first.
  task automatic two_words(input string tag, input logic [31:0] a, input logic [31:0] b, input int gap);
    int w, vcnt, pulses, first_at, last_at;
    bit take;
    vcnt = 0; pulses = 0; first_at = -1; last_at = -1;
    send32(a, 1'b1, w);
    p32_data = b;
    if (gap > 0) p32_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == gap) p32_valid = 1'b1;
      @(negedge clk);
      if (s32_valid) vcnt++;
      if (p32_ready) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else last_at = i;
      end
      take = p32_ready && p32_valid;
      @(posedge clk); #1;
      if (take) p32_valid = 1'b0;
    end
    @(negedge clk);
    check_value({tag, "_valid_end"}, {31'd0, s32_valid}, 32'd0);
    check_value({tag, "_ready_end"}, {31'd0, p32_ready}, 32'd1);
    @(posedge clk); #1;
    p32_valid = 1'b0;
    check_value({tag, "_valid_cycles"}, 32'(vcnt), 32'd64);
    check_value({tag, "_ready_pulses"}, 32'(pulses), 32'd2);
    check_value({tag, "_ready_pulse1"}, 32'(first_at), 32'd31);
    check_value({tag, "_ready_pulse2"}, 32'(last_at), 32'd63);
  endtask

  // Hard time bound so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, n, ncyc;
    logic [2:0] held;

    reset = 1'b1;
    p32_data = 32'd0; p32_valid = 1'b0; s32_ready = 1'b1;
    p8_data  = 8'd0;  p8_valid  = 1'b0; s8_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_valid", {31'd0, s32_valid}, 32'd0);
    check_value("rst_busy", {31'd0, busy32}, 32'd0);
    check_value("rst_out", {31'd0, s32_out}, 32'd0);
    check_value("rst_first_last", {30'd0, s32_first, s32_last}, 32'd0);
    check_value("rst_par_ready", {31'd0, p32_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check_value("idle_par_ready", {31'd0, p32_ready}, 32'd1);
    @(posedge clk); #1;

    // Single word, MSB first.
    send32(32'hFFFF_FFFA, 1'b0, w);
    drain32("single", n);
    check_value("single_valid_cycles", 32'(n), 32'd32);

    // Back-to-back with par_valid held high.
    two_words("b2b", 32'hFFFF_FFFA, 32'hBBAF_FFFF, 0);

    // Stall five cycles while bit 10 is presented.
    send32(32'hA5A5_A5A5, 1'b0, w);
    ncyc = 0;
    held = 3'd0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!s32_valid) break;
      ncyc++;
      if (c == 9) held = {s32_out, s32_first, s32_last};
      if (c >= 10 && c <= 14)
        check_value("stall_hold", {29'd0, s32_out, s32_first, s32_last}, {29'd0, held});
      @(posedge clk); #1;
      s32_ready = !((c + 1) >= 9 && (c + 1) <= 13);
    end
    s32_ready = 1'b1;
    check_value("stall_total_cycles", 32'(ncyc), 32'd37);
    @(posedge clk); #1;

    // LSB-first 8-bit instance.
    send8(8'h0A, w);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!s8_valid) break;
      n++;
      @(posedge clk); #1;
    end
    check_value("lsb8_valid_cycles", 32'(n), 32'd8);
    check_value("lsb8_busy_after", {31'd0, busy8}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset while bit 17 is on the line.
    send32(32'h1234_5678, 1'b0, w);
    repeat (16) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check_value("async_rst_valid", {31'd0, s32_valid}, 32'd0);
    check_value("async_rst_busy", {31'd0, busy32}, 32'd0);
    check_value("async_rst_out", {31'd0, s32_out}, 32'd0);
    check_value("async_rst_par_ready", {31'd0, p32_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    send32(32'h0000_0001, 1'b0, w);
    check_value("post_rst_accept_wait", 32'(w), 32'd1);
    drain32("post_rst", n);
    check_value("post_rst_valid_cycles", 32'(n), 32'd32);

    // New word offered mid-word must wait for the last-bit beat.
    two_words("midword", 32'hC3C3_0F0F, 32'h1234_ABCD, 5);

    repeat (2) @(posedge clk);
    #1;
    check_value("sb32_empty", 32'(q32.size()), 32'd0);
    check_value("sb8_empty", 32'(q8.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter that accepts a WIDTH-bit word through a valid/ready handshake. It shifts the word out one bit per accepted serial beat, with first/last framing flags. It is the serial-link counterpart to the team's parallel-load register path: words produced by the PIPO stage are fed here for transmission to a downstream bit-serial receiver. Back-to-back words stream with no idle bubble.

Parameters:
WIDTH, 32, parallel word width in bits (legal range WIDTH >= 2).
LSB_FIRST, 0, bit order. 0 = bit WIDTH-1 is sent first. 1 = bit 0 is sent first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
par_data  input  WIDTH  parallel word to transmit.
par_valid  input  1  par_data is valid.
par_ready  output  1  block can accept a word this cycle.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out holds a valid bit.
ser_ready  input  1  downstream accepts ser_out this cycle.
ser_first  output  1  ser_out is the first bit of a word.
ser_last  output  1  ser_out is the last bit of a word.
busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; shift register = 0; bit counter = 0.
  - ser_out = 0, ser_valid = 0, ser_first = 0, ser_last = 0, busy = 0.
  - par_ready is forced to 0 while reset is high.
- Handshakes:
  - Parallel transfer occurs on a rising edge where par_valid && par_ready.
  - Serial beat occurs on a rising edge where ser_valid && ser_ready.
- State machine, two states:
  - IDLE:
    - par_ready = 1, ser_valid = 0.
    - On a parallel transfer: load par_data into the shift register, counter = 0, go to SHIFT.
  - SHIFT:
    - ser_valid = 1, busy = 1.
    - ser_out = shift-register MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1). It is driven directly from a register, with no combinational path from par_data.
    - On each serial beat: shift one position toward the output end, zero-fill, counter += 1.
    - On the beat where counter == WIDTH-1 (the last bit):
      - If a parallel transfer occurs on the same edge, load the new word, counter = 0, stay in SHIFT (no bubble).
      - Otherwise go to IDLE.
- par_ready in SHIFT = (counter == WIDTH-1) && ser_ready. This is the only combinational input-to-output path. par_ready is 0 at all other times in SHIFT.
- ser_first = busy && (counter == 0). ser_last = busy && (counter == WIDTH-1).
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1 and wraps only by reload.
- Latency: a word accepted at edge N has its first bit valid in the cycle after edge N. With ser_ready held at 1, a word occupies exactly WIDTH cycles.
- Stall: while ser_ready = 0 in SHIFT, the shift register, counter, ser_out and flags hold unchanged.
- par_valid during SHIFT before the last bit is ignored. par_data is not sampled and no word is lost, because the upstream holds the word until par_ready.
- Reset mid-word: the partial word is discarded and no further bits are emitted. After reset releases, the block is in IDLE and accepts a word the first cycle reset is low.
- ser_out is a don't-care when ser_valid = 0, but the implementation drives 0.

Test Plan:
- Reset, then a single word 32'hFFFFFFFA, LSB_FIRST=0, ser_ready=1 -> ser_valid high for 32 cycles.
  - Bits are 1 x28, then 1,0,1,0.
  - ser_first on bit 1; ser_last on bit 32 (value 0).
  - busy drops and par_ready rises the cycle after.
- Back-to-back words 32'hFFFFFFFA then 32'hBBAFFFFF, par_valid held high -> 64 contiguous ser_valid cycles.
  - par_ready pulses only on the last-bit cycle.
  - ser_first on cycles 1 and 33.
  - Bits 33-36 are 1,0,1,1 (nibble B).
- Stall: drop ser_ready for 5 cycles at bit 10 of 32'hA5A5A5A5 -> ser_out and counter frozen during the stall. The full word arrives intact in 37 cycles.
- LSB_FIRST=1, WIDTH=8, word 8'h0A -> bits 0,1,0,1,0,0,0,0; ser_last on the 8th bit.
- Assert reset at bit 17 of a 32-bit word -> ser_valid, busy and ser_out go 0 immediately, without waiting for a clock edge. After release, a new word 32'h00000001 is transmitted fully and correctly.
- par_valid asserted with new data mid-word -> the new data is ignored until the last-bit cycle, and the current word's bit stream is unaffected.
